// File: rtl/color_pkg.sv
// Shared colour codes, per-colour RGB targets and the lookup used by the RGB fade/PWM stage.
package color_pkg;

    localparam int PWM_BITS = 8;

    typedef enum logic [1:0] {
        NATURAL = 2'b00,
        WHITE   = 2'b01,
        BLUE    = 2'b10,
        ORANGE  = 2'b11
    } color_e;

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_NATURAL = '{r: 8'd255, g: 8'd180, b: 8'd100};
    localparam rgb_t RGB_WHITE   = '{r: 8'd255, g: 8'd255, b: 8'd255};
    localparam rgb_t RGB_BLUE    = '{r: 8'd0,   g: 8'd0,   b: 8'd255};
    localparam rgb_t RGB_ORANGE  = '{r: 8'd255, g: 8'd100, b: 8'd0};
    localparam rgb_t RGB_OFF     = '{r: 8'd0,   g: 8'd0,   b: 8'd0};

    // Lamp off overrides any colour selection.
    function automatic rgb_t color_target(input logic [1:0] color, input logic light_on);
        rgb_t t;
        t = RGB_OFF;
        if (light_on) begin
            case (color)
                NATURAL: t = RGB_NATURAL;
                WHITE:   t = RGB_WHITE;
                BLUE:    t = RGB_BLUE;
                ORANGE:  t = RGB_ORANGE;
                default: t = RGB_OFF;
            endcase
        end else begin
            t = RGB_OFF;
        end
        return t;
    endfunction

endpackage

// File: rtl/fade_channel.sv
// One LED channel: level ramp toward target, per-period duty latch and registered PWM output.
module fade_channel
    import color_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] target,
    input  logic                fade_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                pwm_wrap,
    output logic [PWM_BITS-1:0] level,
    output logic                led
);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty_q,  duty_d;
    logic                led_q,   led_d;

    // Next-state: single-step ramp, duty capture at period end, PWM compare.
    always_comb begin
        level_d = level_q;
        duty_d  = duty_q;
        led_d   = 1'b0;
        if (fade_tick) begin
            if (level_q < target) begin
                level_d = level_q + 8'd1;
            end else if (level_q > target) begin
                level_d = level_q - 8'd1;
            end else begin
                level_d = level_q;
            end
        end else begin
            level_d = level_q;
        end
        // level_q is the pre-step value, so a coincident tick is not seen by the latch.
        if (pwm_wrap) begin
            duty_d = level_q;
        end else begin
            duty_d = duty_q;
        end
        led_d = (pwm_cnt < duty_q);
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 8'd0;
            duty_q  <= 8'd0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
        end
    end

    assign level = level_q;
    assign led   = led_q;

endmodule

// File: rtl/rgb_fade_pwm.sv
// Colour-code to RGB target mapping with linear fading and three PWM LED drivers.
module rgb_fade_pwm
    import color_pkg::*;
#(
    parameter int unsigned FADE_DIV = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          color,
    input  logic                light_on,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic [PWM_BITS-1:0] level_r,
    output logic [PWM_BITS-1:0] level_g,
    output logic [PWM_BITS-1:0] level_b,
    output logic                fading
);

    localparam int FC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [FC_W-1:0]     fade_cnt_q, fade_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic                fading_q,   fading_d;
    logic                fade_tick;
    logic                pwm_wrap;
    rgb_t                target;

    // Counters, target lookup and settle detection.
    always_comb begin
        fade_tick = (fade_cnt_q == FC_W'(FADE_DIV - 1));
        pwm_wrap  = (pwm_cnt_q == 8'hFF);
        if (fade_tick) begin
            fade_cnt_d = '0;
        end else begin
            fade_cnt_d = fade_cnt_q + FC_W'(1);
        end
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        target    = color_target(color, light_on);
        fading_d  = (level_r != target.r) || (level_g != target.g) || (level_b != target.b);
    end

    // Shared timebase and fading flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fade_cnt_q <= '0;
            pwm_cnt_q  <= 8'd0;
            fading_q   <= 1'b0;
        end else begin
            fade_cnt_q <= fade_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fading_q   <= fading_d;
        end
    end

    assign fading = fading_q;

    fade_channel u_ch_r (
        .clk      (clk),
        .reset    (reset),
        .target   (target.r),
        .fade_tick(fade_tick),
        .pwm_cnt  (pwm_cnt_q),
        .pwm_wrap (pwm_wrap),
        .level    (level_r),
        .led      (led_r)
    );

    fade_channel u_ch_g (
        .clk      (clk),
        .reset    (reset),
        .target   (target.g),
        .fade_tick(fade_tick),
        .pwm_cnt  (pwm_cnt_q),
        .pwm_wrap (pwm_wrap),
        .level    (level_g),
        .led      (led_g)
    );

    fade_channel u_ch_b (
        .clk      (clk),
        .reset    (reset),
        .target   (target.b),
        .fade_tick(fade_tick),
        .pwm_cnt  (pwm_cnt_q),
        .pwm_wrap (pwm_wrap),
        .level    (level_b),
        .led      (led_b)
    );

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Self-checking bench for rgb_fade_pwm: cycle model from clock count arithmetic, table vectors, corner sequences.
module tb_rgb_fade_pwm;

    localparam int FADE_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] color;
    logic       light_on;
    logic       led_r, led_g, led_b;
    logic [7:0] level_r, level_g, level_b;
    logic       fading;

    rgb_fade_pwm #(.FADE_DIV(FADE_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .color   (color),
        .light_on(light_on),
        .led_r   (led_r),
        .led_g   (led_g),
        .led_b   (led_b),
        .level_r (level_r),
        .level_g (level_g),
        .level_b (level_b),
        .fading  (fading)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: t = clock edges since reset release.
    int t;
    int m_lvl[3];
    int m_duty[3];
    bit m_led[3];
    bit m_fad;
    int tgt_tab[4][3];

    typedef struct {
        logic [1:0] color;
        logic       on;
        int         ncyc;
        int         er, eg, eb;
        logic       efad;
    } vec_t;
    vec_t tbl[6];

    task automatic model_reset();
        t = 0;
        m_fad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_lvl[c] = 0; m_duty[c] = 0; m_led[c] = 1'b0;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, got, exp, t);
        end
    endtask

    function automatic int dut_led(input int c);
        return (c == 0) ? int'(led_r) : (c == 1) ? int'(led_g) : int'(led_b);
    endfunction

    task automatic step();
        int tgt[3];
        int p;
        bit tick;
        @(posedge clk);
        p    = t % 256;
        tick = ((t % FADE_DIV) == FADE_DIV - 1);
        for (int c = 0; c < 3; c++) tgt[c] = light_on ? tgt_tab[color][c] : 0;
        m_fad = (m_lvl[0] != tgt[0]) || (m_lvl[1] != tgt[1]) || (m_lvl[2] != tgt[2]);
        for (int c = 0; c < 3; c++) begin
            m_led[c] = (p < m_duty[c]);
            if (p == 255) m_duty[c] = m_lvl[c];
            if (tick) m_lvl[c] += (tgt[c] > m_lvl[c]) - (tgt[c] < m_lvl[c]);
        end
        t++;
        #1;
        vectors++;
        if (level_r != 8'(m_lvl[0]) || level_g != 8'(m_lvl[1]) || level_b != 8'(m_lvl[2]) ||
            led_r != m_led[0] || led_g != m_led[1] || led_b != m_led[2] || fading != m_fad) begin
            miscompares++;
            $display("FAIL cycle t=%0d: got lvl %0d/%0d/%0d led %b%b%b fading %b, want lvl %0d/%0d/%0d led %b%b%b fading %b",
                     t, level_r, level_g, level_b, led_r, led_g, led_b, fading,
                     m_lvl[0], m_lvl[1], m_lvl[2], m_led[0], m_led[1], m_led[2], m_fad);
        end
    endtask

    task automatic count_led(input int c, input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step();
            highs += dut_led(c);
        end
    endtask

    initial begin
        int highs;
        int exp_duty;
        int guard;

        tgt_tab[0] = '{255, 180, 100};
        tgt_tab[1] = '{255, 255, 255};
        tgt_tab[2] = '{0, 0, 255};
        tgt_tab[3] = '{255, 100, 0};

        tbl[0] = '{color: 2'd0, on: 1'b0, ncyc: 2000, er: 0,   eg: 0,   eb: 0,   efad: 1'b0};
        tbl[1] = '{color: 2'd1, on: 1'b1, ncyc: 1021, er: 255, eg: 255, eb: 255, efad: 1'b0};
        tbl[2] = '{color: 2'd1, on: 1'b1, ncyc: 600,  er: 255, eg: 255, eb: 255, efad: 1'b0};
        tbl[3] = '{color: 2'd2, on: 1'b1, ncyc: 1021, er: 0,   eg: 0,   eb: 255, efad: 1'b0};
        tbl[4] = '{color: 2'd2, on: 1'b1, ncyc: 600,  er: 0,   eg: 0,   eb: 255, efad: 1'b0};
        tbl[5] = '{color: 2'd2, on: 1'b0, ncyc: 1021, er: 0,   eg: 0,   eb: 0,   efad: 1'b0};

        reset = 1'b1; color = 2'd0; light_on = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset level_r", level_r, 0);
        check("reset led", {led_r, led_g, led_b}, 0);
        check("reset fading", fading, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int v = 0; v < 6; v++) begin
            color = tbl[v].color;
            light_on = tbl[v].on;
            if (v == 1) begin
                step();
                check("fade-up fading within 1 clk", fading, 1);
                for (int i = 1; i < tbl[v].ncyc; i++) step();
            end else begin
                for (int i = 0; i < tbl[v].ncyc; i++) step();
            end
            check($sformatf("vec%0d level_r", v), level_r, tbl[v].er);
            check($sformatf("vec%0d level_g", v), level_g, tbl[v].eg);
            check($sformatf("vec%0d level_b", v), level_b, tbl[v].eb);
            check($sformatf("vec%0d fading", v), fading, tbl[v].efad);
            if (v == 2) begin
                count_led(0, 256, highs);
                check("white led_r highs per period", highs, 255);
            end
            if (v == 4) begin
                count_led(0, 256, highs);
                check("blue led_r highs", highs, 0);
                count_led(1, 256, highs);
                check("blue led_g highs", highs, 0);
            end
        end

        // Duty latch: retarget while pwm_cnt==100, duty must hold until wrap.
        repeat (300) step();
        guard = 0;
        while ((t % 256) != 100 && guard < 300) begin
            step();
            guard++;
        end
        check("reach pwm_cnt 100", t % 256, 100);
        color = 2'd1; light_on = 1'b1;
        count_led(0, 156, highs);
        check("duty stable in current period", highs, 0);
        exp_duty = m_duty[0];
        count_led(0, 256, highs);
        check("new duty after wrap", highs, exp_duty);

        // Reset asserted asynchronously mid-fade.
        repeat (50) step();
        #2;
        reset = 1'b1;
        #1;
        check("async reset level_r", level_r, 0);
        check("async reset level_b", level_b, 0);
        check("async reset leds", {led_r, led_g, led_b}, 0);
        check("async reset fading", fading, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Fade restarts from 0 (ORANGE), then retarget to NATURAL at level_g==50.
        color = 2'd3; light_on = 1'b1;
        repeat (40) step();
        check("restart level_r after 40 clk", level_r, 10);
        guard = 0;
        while (m_lvl[1] != 50 && guard < 1000) begin
            step();
            guard++;
        end
        check("level_g reached 50", level_g, 50);
        color = 2'd0;
        guard = 0;
        while (level_g == 8'd50 && guard < 8) begin
            step();
            guard++;
        end
        check("retarget level_g next step", level_g, 51);
        guard = 0;
        while ((fading || m_fad || guard < 2) && guard < 2000) begin
            step();
            guard++;
        end
        check("retarget final level_r", level_r, 255);
        check("retarget final level_g", level_g, 180);
        check("retarget final level_b", level_b, 100);
        check("retarget fading clear", fading, 0);

        // Random segments against the model.
        for (int s = 0; s < 12; s++) begin
            color = 2'($urandom_range(0, 3));
            light_on = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 400)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
